// File: rtl/systolic_result_drain_pkg.sv
// Shared definitions for the systolic result drain: FSM encoding and
// the bank/word address split used on the SRAM write port.
package systolic_result_drain_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } drain_state_e;

   localparam int ROW_CNT_W = 16;

   // Bank-select field width; a single-bank system still carries one bit.
   function automatic int bank_bits(input int banks);
      return (banks > 1) ? $clog2(banks) : 1;
   endfunction

endpackage

// File: rtl/systolic_result_drain_row_fifo.sv
// Two-entry row buffer between the systolic array and the SRAM write port.
// The head entry is read straight from storage, so it is already registered.
module drain_row_fifo #(
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   // A full FIFO refuses a push even when it is popped in the same cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/systolic_result_drain.sv
// Drains result rows from the systolic array into banked SRAM, one row per
// word at consecutive (wrapping) global addresses starting at dst_addr.
module systolic_result_drain
   import systolic_result_drain_pkg::*;
#(
   parameter  int ARRAY_SIZE = 4,
   parameter  int ACC_WIDTH  = 32,
   parameter  int SRAM_WIDTH = 256,
   parameter  int SRAM_BANKS = 4,
   parameter  int ADDR_WIDTH = 20,
   localparam int BANK_W     = bank_bits(SRAM_BANKS),
   localparam int ROW_W      = ARRAY_SIZE * ACC_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDR_WIDTH-1:0]    dst_addr,
   input  logic [ROW_CNT_W-1:0]     num_rows,
   input  logic                     row_valid,
   input  logic [ROW_W-1:0]         row_data,
   output logic                     row_ready,
   output logic                     sram_we,
   output logic [BANK_W-1:0]        sram_bank,
   output logic [ADDR_WIDTH-BANK_W-1:0] sram_addr,
   output logic [SRAM_WIDTH-1:0]    sram_wdata,
   input  logic                     sram_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   drain_state_e          state;
   drain_state_e          next_state;
   logic [ADDR_WIDTH-1:0] dst_q;
   logic [ROW_CNT_W-1:0]  num_q;
   logic [ROW_CNT_W-1:0]  acc_cnt;
   logic [ROW_CNT_W-1:0]  wr_cnt;
   logic [ROW_W-1:0]      head;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  pop;
   logic                  launch;
   logic [ADDR_WIDTH-1:0] g_addr;

   drain_row_fifo #(.WIDTH(ROW_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (row_data),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign launch    = (state == ST_IDLE) && start;
   assign row_ready = (state == ST_DRAIN) && !fifo_full && (acc_cnt < num_q);
   assign push      = row_valid && row_ready;
   assign sram_we   = (state == ST_DRAIN) && !fifo_empty;
   assign pop       = sram_we && sram_ready;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);

   // Write fields come only from registered state, so they hold while stalled.
   assign g_addr     = dst_q + ADDR_WIDTH'(wr_cnt);
   assign sram_bank  = sram_we ? g_addr[BANK_W-1:0] : '0;
   assign sram_addr  = sram_we ? g_addr[ADDR_WIDTH-1:BANK_W] : '0;
   assign sram_wdata = sram_we ? SRAM_WIDTH'(head) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (start) next_state = (num_rows == '0) ? ST_DONE : ST_DRAIN;
         ST_DRAIN: if (pop && (wr_cnt == num_q - 1'b1)) next_state = ST_DONE;
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dst_q   <= '0;
         num_q   <= '0;
         acc_cnt <= '0;
         wr_cnt  <= '0;
         error   <= 1'b0;
      end else if (launch) begin
         dst_q   <= dst_addr;
         num_q   <= num_rows;
         acc_cnt <= '0;
         wr_cnt  <= '0;
         error   <= 1'b0;
      end else begin
         if (push) acc_cnt <= acc_cnt + 1'b1;
         if (pop)  wr_cnt  <= wr_cnt + 1'b1;
         // Rows offered when nothing is expecting them are a producer bug.
         if (row_valid && ((state != ST_DRAIN) || (acc_cnt >= num_q))) error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain: table of jobs plus
// hand-written sequences for zero rows, protocol errors and mid-job reset.
module tb_systolic_result_drain;

   localparam int ARRAY_SIZE = 4;
   localparam int ACC_WIDTH  = 32;
   localparam int SRAM_WIDTH = 256;
   localparam int SRAM_BANKS = 4;
   localparam int ADDR_WIDTH = 20;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [19:0]  dst_addr;
   logic [15:0]  num_rows;
   logic         row_valid;
   logic [127:0] row_data;
   logic         row_ready;
   logic         sram_we;
   logic [1:0]   sram_bank;
   logic [17:0]  sram_addr;
   logic [255:0] sram_wdata;
   logic         sram_ready;
   logic         busy;
   logic         done;
   logic         error;

   systolic_result_drain #(
      .ARRAY_SIZE(ARRAY_SIZE), .ACC_WIDTH(ACC_WIDTH), .SRAM_WIDTH(SRAM_WIDTH),
      .SRAM_BANKS(SRAM_BANKS), .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr), .num_rows(num_rows),
      .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
      .sram_we(sram_we), .sram_bank(sram_bank), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_ready(sram_ready),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   bank;
      logic [17:0]  addr;
      logic [255:0] data;
   } wr_t;

   typedef struct {
      logic [19:0] dst;
      int          n;
      int          stall_at;
      int          stall_len;
      bit          restart;
      bit          extra;
      bit          exp_drop;
      logic [1:0]  exp_bank0;
      logic [17:0] exp_addr0;
   } job_t;

   wr_t          exp_q[$];
   wr_t          e;
   job_t         jobs[5];
   logic [127:0] rows_tbl[4];

   int n_checks = 0;
   int n_pass   = 0;

   logic [19:0] job_dst;
   int          job_n;
   int          acc_count;
   int          wr_count;
   int          done_pulses;
   int          ready_drops;
   bit          first_seen;
   logic [1:0]  first_bank;
   logic [17:0] first_addr;
   bit          prev_stall;
   logic [20:0] prev_ctl;
   logic [255:0] prev_wdata;
   logic [19:0] g;

   function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   function automatic logic [127:0] pack4(int a, int b, int c, int d);
      return {d, c, b, a};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor and scoreboard: sampled on the falling edge, between active edges.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_ctl", 256'({sram_we, sram_bank, sram_addr}), 256'(prev_ctl));
            chk("hold_wdata", sram_wdata, prev_wdata);
         end
         if (row_valid && !row_ready && busy && (acc_count < job_n)) begin
            ready_drops++;
            chk("ready_drop_occupancy", 256'(acc_count - wr_count), 256'(2));
         end
         if (sram_we && sram_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_write", 256'(sram_we), 256'(0));
            end else begin
               e = exp_q.pop_front();
               chk("wr_bank", 256'(sram_bank), 256'(e.bank));
               chk("wr_addr", 256'(sram_addr), 256'(e.addr));
               chk("wr_data", sram_wdata, e.data);
            end
            if (!first_seen) begin
               first_seen = 1'b1;
               first_bank = sram_bank;
               first_addr = sram_addr;
            end
            wr_count++;
         end
         if (row_valid && row_ready) begin
            g = job_dst + 20'(acc_count);
            exp_q.push_back('{bank: g[1:0], addr: g[19:2], data: {128'd0, rows_tbl[acc_count % 4]}});
            acc_count++;
         end
         prev_stall = sram_we && !sram_ready;
         prev_ctl   = {sram_we, sram_bank, sram_addr};
         prev_wdata = sram_wdata;
         if (done) done_pulses++;
      end
   end

   task automatic new_job(input logic [19:0] dst, input int n);
      job_dst = dst;
      job_n = n;
      acc_count = 0;
      wr_count = 0;
      done_pulses = 0;
      ready_drops = 0;
      first_seen = 1'b0;
      exp_q.delete();
   endtask

   task automatic drive_row(input int r);
      bit got;
      got = 1'b0;
      row_valid = 1'b1;
      row_data = rows_tbl[r % 4];
      for (int w = 0; w < 100 && !got; w++) begin
         @(negedge clk);
         if (row_ready) got = 1'b1;
      end
      chk("row_accept_timeout", 256'(got), 256'(1));
      tick();
   endtask

   task automatic wait_done(input int budget);
      for (int w = 0; w < budget && done_pulses == 0; w++) begin
         @(negedge clk);
         #1;
      end
      chk("done_seen", 256'(done_pulses > 0), 256'(1));
   endtask

   task automatic run_job(input job_t j);
      new_job(j.dst, j.n);
      start = 1'b1;
      dst_addr = j.dst;
      num_rows = 16'(j.n);
      sram_ready = 1'b1;
      tick();
      start = 1'b0;
      fork
         begin
            for (int r = 0; r < j.n; r++) drive_row(r);
            if (j.extra) tick();
            row_valid = 1'b0;
         end
         begin
            repeat (j.stall_at) tick();
            if (j.stall_len > 0) begin
               sram_ready = 1'b0;
               if (j.restart) begin
                  tick();
                  start = 1'b1;
                  dst_addr = 20'h00300;
                  num_rows = 16'd1;
                  tick();
                  start = 1'b0;
                  repeat (j.stall_len - 2) tick();
               end else begin
                  repeat (j.stall_len) tick();
               end
               sram_ready = 1'b1;
            end
         end
      join
      wait_done(100);
      repeat (3) tick();
      chk("done_once", 256'(done_pulses), 256'(1));
      chk("writes_total", 256'(wr_count), 256'(j.n));
      chk("queue_drained", 256'(exp_q.size()), 256'(0));
      chk("first_bank", 256'(first_bank), 256'(j.exp_bank0));
      chk("first_addr", 256'(first_addr), 256'(j.exp_addr0));
      chk("idle_busy", 256'(busy), 256'(0));
      chk("error_flag", 256'(error), 256'(j.extra));
      if (j.exp_drop) chk("ready_dropped", 256'(ready_drops > 0), 256'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1);
   end

   initial begin
      rows_tbl[0] = pack4(-4662, 13575, -5565, -1731);
      rows_tbl[1] = pack4(14124, -13933, 277, -1784);
      rows_tbl[2] = pack4(-7516, -6534, 3850, 12206);
      rows_tbl[3] = pack4(-13168, 5781, 11355, -9360);
      //           dst        n  st_at len rst ext drop bank0 addr0
      jobs[0] = '{20'h00020, 4, 0, 0, 1'b0, 1'b0, 1'b0, 2'd0, 18'h00008};
      jobs[1] = '{20'h00020, 4, 0, 5, 1'b0, 1'b0, 1'b1, 2'd0, 18'h00008};
      jobs[2] = '{20'hFFFFE, 4, 0, 0, 1'b0, 1'b0, 1'b0, 2'd2, 18'h3FFFF};
      jobs[3] = '{20'h00005, 3, 1, 3, 1'b0, 1'b1, 1'b0, 2'd1, 18'h00001};
      jobs[4] = '{20'h00040, 4, 0, 6, 1'b1, 1'b0, 1'b1, 2'd0, 18'h00010};

      new_job(20'd0, 0);
      rst = 1'b1;
      start = 1'b0;
      dst_addr = '0;
      num_rows = '0;
      row_valid = 1'b0;
      row_data = '0;
      sram_ready = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      chk("rst_outputs", 256'({row_ready, sram_we, sram_bank, sram_addr, busy, done, error}), 256'(0));
      chk("rst_wdata", sram_wdata, 256'(0));
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_job(jobs[i]);

      // Zero-row job: straight to completion without touching SRAM.
      new_job(20'h00100, 0);
      start = 1'b1;
      dst_addr = 20'h00100;
      num_rows = 16'd0;
      tick();
      start = 1'b0;
      repeat (3) tick();
      chk("zero_done_once", 256'(done_pulses), 256'(1));
      chk("zero_no_write", 256'(wr_count), 256'(0));
      chk("zero_idle", 256'(busy), 256'(0));

      // Stray row in IDLE sets a sticky error cleared only by the next start.
      row_valid = 1'b1;
      row_data = rows_tbl[0];
      tick();
      row_valid = 1'b0;
      repeat (3) tick();
      chk("idle_row_error", 256'(error), 256'(1));
      new_job(20'h00000, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      chk("error_cleared_by_start", 256'(error), 256'(0));
      repeat (3) tick();

      // Reset with two rows buffered and a write pending.
      new_job(20'h00020, 4);
      start = 1'b1;
      dst_addr = 20'h00020;
      num_rows = 16'd4;
      sram_ready = 1'b0;
      tick();
      start = 1'b0;
      drive_row(0);
      drive_row(1);
      chk("pre_reset_we", 256'(sram_we), 256'(1));
      rst = 1'b1;
      #1;
      chk("midrst_outputs", 256'({row_ready, sram_we, sram_bank, sram_addr, busy, done, error}), 256'(0));
      chk("midrst_wdata", sram_wdata, 256'(0));
      row_valid = 1'b0;
      sram_ready = 1'b1;
      tick();
      rst = 1'b0;
      new_job(20'h00020, 4);
      repeat (8) tick();
      chk("midrst_no_done", 256'(done_pulses), 256'(0));
      chk("midrst_no_write", 256'(wr_count), 256'(0));
      chk("midrst_idle", 256'({busy, error}), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
